// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: segment type,
// blank pattern and the active-low hex glyph table ({a,b,c,d,e,f,g}).
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } slot_phase_t;

  localparam seg7_t SEG_OFF = 7'h7F;

  localparam seg7_t HEX_SEG [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  function automatic seg7_t hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_sched.sv
// Multiplexed scan scheduler for a multi-digit 7-segment display with
// per-slot blanking and frame-synchronous payload updates.
module seg7_scan_sched
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int TICK_DIV  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  output logic                  load_ready_o,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     en_i,
  output logic [DIGITS-1:0]     an_o,
  output seg7_t                 seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;

  logic [4*DIGITS-1:0] pend_data_reg, act_data_reg;
  logic [DIGITS-1:0]   pend_dp_reg, act_dp_reg;
  logic [DIGITS-1:0]   pend_en_reg, act_en_reg;
  logic                pend_valid_reg;

  logic [DIGITS-1:0]   an_reg, an_next;
  seg7_t               seg_reg, seg_next;
  logic                dp_reg, dp_next;
  logic                frame_reg, frame_next;

  logic                slot_end;
  logic                frame_wrap;
  logic                transfer;
  slot_phase_t         phase;
  logic                show;
  logic [3:0]          cur_nibble;
  seg7_t               dec_seg;

  assign slot_end   = (cnt_reg == CNT_W'(TICK_DIV - 1));
  assign frame_wrap = slot_end && (idx_reg == IDX_W'(DIGITS - 1));
  assign transfer   = load_i && !pend_valid_reg;
  assign cur_nibble = act_data_reg[4*idx_reg +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    phase      = PH_SHOW;
    seg_next   = SEG_OFF;
    dp_next    = 1'b1;
    frame_next = frame_wrap;
    if (slot_end) begin
      cnt_next = '0;
      idx_next = (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end
    if (BLANK_CYC != 0 && cnt_reg < CNT_W'(BLANK_CYC)) begin
      phase = PH_BLANK;
    end
    if (phase == PH_SHOW) begin
      seg_next = dec_seg;
      dp_next  = ~act_dp_reg[idx_reg];
    end
  end

  assign show = (phase == PH_SHOW);

  // Disabled digits keep their slot but never drive the anode.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_anode
    assign an_next[gi] = ~(show && act_en_reg[gi] && (idx_reg == IDX_W'(gi)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      pend_data_reg  <= '0;
      pend_dp_reg    <= '0;
      pend_en_reg    <= '0;
      pend_valid_reg <= 1'b0;
      act_data_reg   <= '0;
      act_dp_reg     <= '0;
      act_en_reg     <= '0;
      an_reg         <= '1;
      seg_reg        <= SEG_OFF;
      dp_reg         <= 1'b1;
      frame_reg      <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      an_reg    <= an_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
      frame_reg <= frame_next;
      // A transfer cannot coincide with a pending apply: ready is low while pending is full.
      if (frame_wrap && pend_valid_reg) begin
        act_data_reg   <= pend_data_reg;
        act_dp_reg     <= pend_dp_reg;
        act_en_reg     <= pend_en_reg;
        pend_valid_reg <= 1'b0;
      end else if (transfer) begin
        pend_data_reg  <= data_i;
        pend_dp_reg    <= dp_i;
        pend_en_reg    <= en_i;
        pend_valid_reg <= 1'b1;
      end
    end
  end

  assign load_ready_o = ~pend_valid_reg;
  assign an_o         = an_reg;
  assign seg_o        = seg_reg;
  assign dp_o         = dp_reg;
  assign frame_o      = frame_reg;

endmodule

// File: tb/tb_seg7_scan_sched.sv
// Scoreboard bench for seg7_scan_sched: expected outputs are queued per cycle
// from a behavioural frame-position model and compared after each clock edge.
module tb_seg7_scan_sched;

  localparam int D = 8;
  localparam int T = 10;
  localparam int B = 2;
  localparam int F = D * T;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        load_i = 1'b0;
  logic        load_ready_o;
  logic [31:0] data_i = '0;
  logic [7:0]  dp_i = '0;
  logic [7:0]  en_i = '0;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;

  always #5 clk = ~clk;

  seg7_scan_sched #(
    .DIGITS    (D),
    .TICK_DIV  (T),
    .BLANK_CYC (B)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .load_i       (load_i),
    .load_ready_o (load_ready_o),
    .data_i       (data_i),
    .dp_i         (dp_i),
    .en_i         (en_i),
    .an_o         (an_o),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .frame_o      (frame_o)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int          m_s;
  logic [31:0] m_act_data, m_pend_data;
  logic [7:0]  m_act_dp, m_pend_dp, m_act_en, m_pend_en;
  bit          m_pv;

  int cyc = 0;
  int last_frame = -1;
  bit counting = 0;
  int anode_low [8];
  int frame_seen;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: predict outputs for the coming edge, then compare after it.
  task automatic step();
    exp_t e;
    exp_t o;
    int pos, slot, c;
    bit show;
    if (rst_i) begin
      m_s = 0;
      m_act_data = '0; m_act_dp = '0; m_act_en = '0;
      m_pend_data = '0; m_pend_dp = '0; m_pend_en = '0;
      m_pv = 0;
      e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.frame = 1'b0;
    end else begin
      pos  = m_s % F;
      slot = pos / T;
      c    = pos % T;
      show = (c >= B);
      e.an    = (show && m_act_en[slot]) ? ~(8'h01 << slot) : 8'hFF;
      e.seg   = show ? hex7(m_act_data[slot*4 +: 4]) : 7'h7F;
      e.dp    = show ? ~m_act_dp[slot] : 1'b1;
      e.frame = (pos == F - 1);
      if (pos == F - 1 && m_pv) begin
        m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_en = m_pend_en;
        m_pv = 0;
      end else if (load_i && !m_pv) begin
        m_pend_data = data_i; m_pend_dp = dp_i; m_pend_en = en_i;
        m_pv = 1;
      end
      m_s++;
    end
    e.ready = !m_pv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    o = exp_q.pop_front();
    check("an_o", 32'(an_o), 32'(o.an));
    check("seg_o", 32'(seg_o), 32'(o.seg));
    check("dp_o", 32'(dp_o), 32'(o.dp));
    check("frame_o", 32'(frame_o), 32'(o.frame));
    check("load_ready_o", 32'(load_ready_o), 32'(o.ready));
    if (rst_i) last_frame = -1;
    if (frame_o) begin
      if (last_frame >= 0) check("frame_period", cyc - last_frame, F);
      last_frame = cyc;
    end
    if (counting) begin
      for (int k = 0; k < 8; k++) if (!an_o[k]) anode_low[k]++;
      if (frame_o) frame_seen++;
    end
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while ((m_s % F) != target && n < 4 * F) begin
      step();
      n++;
    end
    check("run_to_bound", 32'(n < 4 * F), 32'd1);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    bit acc = 0;
    int n = 0;
    load_i = 1'b1; data_i = d; dp_i = p; en_i = e;
    while (!acc && n < 4 * F) begin
      acc = !m_pv;
      step();
      n++;
    end
    load_i = 1'b0;
    data_i = $urandom;
    dp_i = 8'($urandom);
    en_i = 8'($urandom);
    check("load_accept", 32'(acc), 32'd1);
    if (acc) $display("load: data=%08h dp=%02h en=%02h accepted after %0d cycles (cycle %0d)", d, p, e, n, cyc);
  endtask

  task automatic measure_frame(input logic [7:0] exp_en);
    for (int k = 0; k < 8; k++) anode_low[k] = 0;
    frame_seen = 0;
    counting = 1;
    repeat (F) step();
    counting = 0;
    for (int k = 0; k < 8; k++) check($sformatf("anode%0d_low_cycles", k), anode_low[k], exp_en[k] ? T - B : 0);
    check("frames_per_window", frame_seen, 1);
    $display("frame window measured: en=%02h frames=%0d", exp_en, frame_seen);
  endtask

  initial begin
    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    repeat (F) step();

    do_load(32'h0123_4567, 8'h01, 8'hFF);
    run_to(F - 1);
    step();
    run_to(B);
    step();
    check("slot0_an", 32'(an_o), 32'h0000_00FE);
    check("slot0_seg", 32'(seg_o), 32'b0001111);
    check("slot0_dp", 32'(dp_o), 32'd0);
    run_to(7 * T + B);
    step();
    check("slot7_an", 32'(an_o), 32'h0000_007F);
    check("slot7_seg", 32'(seg_o), 32'b0000001);
    check("slot7_dp", 32'(dp_o), 32'd1);
    run_to(F - 1);
    step();
    measure_frame(8'hFF);

    do_load(32'h89AB_CDEF, 8'h80, 8'hFF);
    do_load(32'h1357_9BDF, 8'h0F, 8'h0F);
    run_to(F - 1);
    step();
    measure_frame(8'h0F);

    do_load(32'hFEDC_BA98, 8'hFF, 8'hFF);
    run_to(3 * T + 5);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rst_mid_an", 32'(an_o), 32'h0000_00FF);
    check("rst_mid_ready", 32'(load_ready_o), 32'd1);
    repeat (2 * F) step();
    do_load(32'hA5A5_5A5A, 8'h55, 8'hFF);
    repeat (2 * F) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
